inst_fetch_queue: RTL
=====================

// Module: inst_fetch_queue
// PURPOSE
//   Instruction fetch stage upstream of the single-cycle MIPS datapath. Generates sequential
//   word addresses and fetches from a multi-cycle instruction memory with req/ack.
//   Buffers fetched {pc, inst} pairs in a small FIFO and presents them to decode with valid/ready.
//   Branch/jump/jr resolution downstream drives redirect, which flushes the queue.
// PARAMETERS
//   DEPTH     4      FIFO entries (power of two, >=2)
//   RESET_PC  32'h0  first fetch address after reset (word aligned)
// PORTS
//   clock        in   1   rising-edge clock
//   reset        in   1   asynchronous, active-low (0 = in reset)
//   imem_req     out  1   fetch request; held until imem_ack
//   imem_addr    out  30  word address (pc[31:2]); stable while imem_req=1
//   imem_ack     in   1   one-cycle pulse; imem_rdata valid in the same cycle
//   imem_rdata   in   32  fetched instruction word
//   out_valid    out  1   out_inst/out_pc hold a buffered instruction
//   out_inst     out  32  instruction at head of queue
//   out_pc       out  32  byte address of out_inst
//   out_ready    in   1   consumer takes head when out_valid & out_ready
//   redirect     in   1   one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc  in   32  new fetch byte address
//   fetch_fault  out  1   sticky: misaligned redirect_pc received
// BEHAVIOUR
//   Reset (reset=0, async): fetch_pc=RESET_PC, FIFO empty, state IDLE, imem_req=0,
//     imem_addr=RESET_PC[31:2], out_valid=0, out_inst=0, out_pc=0, fetch_fault=0.
//   States: IDLE, WAIT (req outstanding), DISCARD (stale req outstanding), HALT.
//   IDLE: if count + 0 < DEPTH -> assert imem_req, addr=fetch_pc[31:2], go WAIT.
//   WAIT: on imem_ack push {fetch_pc, imem_rdata}, fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0),
//     back to IDLE; next request issues the following cycle at earliest (max 1 outstanding).
//   Credit rule: a request issues only if count < DEPTH, so an ack never finds the FIFO full.
//   Latency: ack in cycle N -> out_valid=1 in cycle N+1 if FIFO was empty (registered output).
//   Head stays stable while out_valid & ~out_ready. Push and pop in one cycle: count unchanged.
//   redirect (aligned): flush FIFO (out_valid=0 next cycle), fetch_pc=redirect_pc.
//     from IDLE -> IDLE; from WAIT without ack -> DISCARD; DISCARD stays DISCARD.
//   DISCARD: imem_req stays high at the old address until imem_ack; ack data dropped; -> IDLE.
//   redirect and imem_ack same cycle: ack data dropped, no DISCARD, -> IDLE.
//   redirect and pop same cycle: redirect wins; the pop does not count as consumed.
//   redirect_pc[1:0]!=0: flush, fetch_fault=1, go HALT (or DISCARD first if req outstanding,
//     then HALT). HALT issues nothing; an aligned redirect clears fetch_fault and resumes.
//   Mid-operation reset: all state returns to reset values immediately; an in-flight ack
//     arriving after reset release is ignored (state is IDLE, not WAIT).
// STRUCTURE
//   Package fetch_pkg: state enum {IDLE, WAIT, DISCARD, HALT}; FETCH_STRIDE=32'd4;
//     typedef fetch_entry_t {logic [31:0] pc; logic [31:0] inst}.
//   Sub-module fetch_fifo: DEPTH x fetch_entry_t, push/pop/flush, count, registered head.
//   Top holds fetch_pc, FSM, imem handshake, fault flag.
// TESTING
//   1 Reset, imem_ack 2 cycles after each req, out_ready=1 -> out_pc 0,4,8,C in order; insts match.
//   2 out_ready=0 -> exactly 4 reqs issued then imem_req stays 0; release -> 4 pops, fetch resumes at 0x10.
//   3 redirect to 0x40 while WAIT, ack 3 cycles later -> ack data dropped, next req addr=0x10 (0x40>>2).
//   4 redirect to 0x80 in same cycle as ack for 0x8 -> 0x8 never appears on out_pc; next out_pc=0x80.
//   5 redirect to 0x42 -> fetch_fault=1, no req; redirect to 0x100 -> fault clears, out_pc=0x100.
//   6 redirect to 0xFFFF_FFF8 -> out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; reset mid-WAIT -> outputs zeroed.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: FSM states, fetch stride
// and the {pc, inst} record buffered between fetch and decode.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,   // ready to issue the next request
        WAIT    = 2'd1,   // request outstanding, data wanted
        DISCARD = 2'd2,   // request outstanding, data stale after a redirect
        HALT    = 2'd3    // misaligned redirect seen, fetch stopped
    } fetch_state_t;

    localparam logic [31:0] FETCH_STRIDE = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, inst} pairs. The head is read
// straight out of the storage registers, so it is valid the cycle after the
// push that filled an empty queue. Flush empties the queue and wins over
// push and pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       valid,
    output fetch_entry_t               head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t        mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic                pop_ok;

    assign pop_ok = pop && (count_q != '0);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        case ({push, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            // NOTE: storage is reset here because the head drives the outputs directly and must read zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign valid = (count_q != '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: walks sequential word addresses, fetches them
// from a multi-cycle memory (one request outstanding at a time) and queues
// {pc, inst} pairs for decode. A redirect flushes the queue and restarts
// fetch; a request already in flight is drained and its data dropped.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clock,
    input  logic          reset,
    output logic          imem_req,
    output logic [29:0]   imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic          out_valid,
    output logic [31:0]   out_inst,
    output logic [31:0]   out_pc,
    input  logic          out_ready,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic          fetch_fault
);

    localparam int             CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

    fetch_state_t   state_q;
    fetch_state_t   state_d;
    logic [31:0]    fetch_pc_q;
    logic [29:0]    addr_q;
    logic           fault_q;
    logic           fault_d;
    logic           redirect_ok;
    logic           redirect_bad;
    logic           can_issue;
    logic           ack_take;
    logic           issue;
    logic [CW-1:0]  fifo_count;
    fetch_entry_t   fifo_head;
    fetch_entry_t   push_entry;

    assign redirect_ok  = redirect && (redirect_pc[1:0] == 2'b00);
    assign redirect_bad = redirect && (redirect_pc[1:0] != 2'b00);
    // Credit check: with one request in flight, a free slot now is still free at the ack.
    assign can_issue    = (fifo_count < FULL_COUNT);
    // Ack data is kept only for a live request with no redirect in the same cycle.
    assign ack_take     = (state_q == WAIT) && imem_ack && !redirect;
    assign issue        = (state_q == IDLE) && (state_d == WAIT);
    // The fault flag doubles as "halt after the drain" while in DISCARD.
    assign fault_d      = redirect ? redirect_bad : fault_q;
    assign push_entry   = '{pc: fetch_pc_q, inst: imem_rdata};

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: redirects take priority over issuing new requests.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (redirect_bad)      state_d = HALT;
                else if (redirect_ok)  state_d = IDLE;
                else if (can_issue)    state_d = WAIT;
            end
            WAIT: begin
                if (redirect) begin
                    if (imem_ack)      state_d = redirect_bad ? HALT : IDLE;
                    else               state_d = DISCARD;
                end else if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                if (imem_ack)          state_d = fault_d ? HALT : IDLE;
            end
            HALT: begin
                if (redirect_ok)       state_d = IDLE;
            end
            default:                   state_d = IDLE;
        endcase
    end

    // Request is held for the whole time a memory access is in flight.
    always_comb begin
        imem_req = (state_q == WAIT) || (state_q == DISCARD);
    end

    // Fetch address, latched request address and sticky fault flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC[31:2];
            fault_q    <= 1'b0;
        end else begin
            fault_q <= fault_d;
            if (redirect_ok) begin
                fetch_pc_q <= redirect_pc;
            end else if (ack_take) begin
                fetch_pc_q <= fetch_pc_q + FETCH_STRIDE;
            end
            if (issue) begin
                addr_q <= fetch_pc_q[31:2];
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (ack_take),
        .push_data (push_entry),
        .pop       (out_ready),
        .flush     (redirect),
        .count     (fifo_count),
        .valid     (out_valid),
        .head      (fifo_head)
    );

    assign imem_addr   = addr_q;
    assign out_pc      = fifo_head.pc;
    assign out_inst    = fifo_head.inst;
    assign fetch_fault = fault_q;

endmodule
